// File: rtl/dff_share_arbiter_if.sv
// dff_share_arbiter_if: request/write-data and grant/register bus of the shared register arbiter
interface dff_share_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
);
  localparam int OW = $clog2(N_REQ);
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] wdata;
  logic [N_REQ-1:0]       gnt;
  logic [OW-1:0]          owner;
  logic [WIDTH-1:0]       q;
  logic                   q_valid;
  logic                   busy;
  modport master (output req, wdata, input gnt, owner, q, q_valid, busy);
  modport slave (input req, wdata, output gnt, owner, q, q_valid, busy);
endinterface

// File: rtl/dff_share_arbiter.sv
// dff_share_arbiter: round-robin arbiter granting one requester at a time write access to a shared register; define DFF_ARB_TIMEOUT_EN to force rotation after MAX_HOLD captures
module dff_share_arbiter #(
  parameter int N_REQ    = 4,
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              reset,
  dff_share_arbiter_if.slave bus
);
  localparam int OW = $clog2(N_REQ);
  if (N_REQ < 2 || N_REQ > 8 || MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_param
    $error("dff_share_arbiter: parameter out of range");
  end
  typedef enum logic {IDLE, OWN} state_t;
  state_t           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d, others;
  logic [OW-1:0]    owner_q, owner_d, ptr_q, ptr_d, win, nxt;
  logic [WIDTH-1:0] q_q, q_d;
  logic             qv_q, qv_d, rotate;
`ifdef DFF_ARB_TIMEOUT_EN
  logic [7:0]       hold_q, hold_d;
`endif
  function automatic logic [OW-1:0] pick(input logic [N_REQ-1:0] m, input logic [OW-1:0] s);
    logic found;
    pick  = s;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      int j;
      j = (int'(s) + k) % N_REQ;
      if (!found && m[j]) begin
        pick  = OW'(j);
        found = 1'b1;
      end
    end
  endfunction
  // next-state: grant from IDLE, capture while the owner requests, otherwise hand over or go idle
  always_comb begin
    nxt     = (owner_q == OW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
    others  = bus.req & ~(N_REQ'(1) << owner_q);
`ifdef DFF_ARB_TIMEOUT_EN
    rotate  = (hold_q == 8'(MAX_HOLD)) && |others;
    hold_d  = hold_q;
`else
    rotate  = 1'b0;
`endif
    win     = (state_q == IDLE) ? pick(bus.req, ptr_q) : pick(others, nxt);
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    q_d     = q_q;
    qv_d    = 1'b0;
    if (state_q == IDLE) begin
      if (|bus.req) begin
        state_d = OWN;
        gnt_d   = N_REQ'(1) << win;
        owner_d = win;
`ifdef DFF_ARB_TIMEOUT_EN
        hold_d  = '0;
`endif
      end
    end else if (bus.req[owner_q] && !rotate) begin
      q_d  = bus.wdata[int'(owner_q)*WIDTH +: WIDTH];
      qv_d = 1'b1;
`ifdef DFF_ARB_TIMEOUT_EN
      hold_d = (hold_q == 8'(MAX_HOLD)) ? hold_q : hold_q + 8'd1;
`endif
    end else begin
      ptr_d = nxt;
      if (|others) begin
        gnt_d   = N_REQ'(1) << win;
        owner_d = win;
`ifdef DFF_ARB_TIMEOUT_EN
        hold_d  = '0;
`endif
      end else begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    end
  end
  // state registers, cleared immediately on reset assertion
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      q_q     <= '0;
      qv_q    <= 1'b0;
`ifdef DFF_ARB_TIMEOUT_EN
      hold_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      q_q     <= q_d;
      qv_q    <= qv_d;
`ifdef DFF_ARB_TIMEOUT_EN
      hold_q  <= hold_d;
`endif
    end
  end
  assign bus.gnt     = gnt_q;
  assign bus.owner   = owner_q;
  assign bus.q       = q_q;
  assign bus.q_valid = qv_q;
  assign bus.busy    = (state_q == OWN);
endmodule

// File: tb/tb_dff_share_arbiter.sv
// tb_dff_share_arbiter: directed vectors with hand-computed expectations for dff_share_arbiter
module tb_dff_share_arbiter;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;
  dff_share_arbiter_if #(.N_REQ(4), .WIDTH(8)) bus ();
  dff_share_arbiter #(.N_REQ(4), .WIDTH(8), .MAX_HOLD(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_reset();
    reset = 1'b0;
    #1;
    reset = 1'b1;
  endtask
  initial begin
    logic [3:0] eg;
    logic       ev;
    reset     = 1'b1;
    bus.req   = '0;
    bus.wdata = '0;
    #1 reset  = 1'b0;
    #2;
    check("rst_gnt", 32'(bus.gnt), 0);
    check("rst_owner", 32'(bus.owner), 0);
    check("rst_q", 32'(bus.q), 0);
    check("rst_qv", 32'(bus.q_valid), 0);
    check("rst_busy", 32'(bus.busy), 0);
    #10;
    reset           = 1'b1;
    bus.req         = 4'b0001;
    bus.wdata[7:0]  = 8'hA5;
    step();
    check("a_gnt", 32'(bus.gnt), 32'b0001);
    check("a_busy", 32'(bus.busy), 1);
    check("a_qv0", 32'(bus.q_valid), 0);
    step();
    check("a_q", 32'(bus.q), 32'hA5);
    check("a_qv1", 32'(bus.q_valid), 1);
    bus.req = 4'b0000;
    step();
    check("a_idle_gnt", 32'(bus.gnt), 0);
    check("a_idle_busy", 32'(bus.busy), 0);
    check("a_idle_qv", 32'(bus.q_valid), 0);
    check("a_idle_q", 32'(bus.q), 32'hA5);
    pulse_reset();
    bus.wdata = {8'h44, 8'h33, 8'h22, 8'h11};
    bus.req   = 4'b1111;
    step();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("b_gnt%0d", i), 32'(bus.gnt), 32'(4'b0001 << i));
      check($sformatf("b_owner%0d", i), 32'(bus.owner), 32'(i));
      check($sformatf("b_qv0_%0d", i), 32'(bus.q_valid), 0);
      step();
      check($sformatf("b_q%0d", i), 32'(bus.q), 32'(8'h11 * (i + 1)));
      check($sformatf("b_qv1_%0d", i), 32'(bus.q_valid), 1);
      step();
      check($sformatf("b_qq%0d", i), 32'(bus.q), 32'(8'h11 * (i + 1)));
      bus.req[i] = 1'b0;
      step();
    end
    check("b_end_gnt", 32'(bus.gnt), 0);
    check("b_end_busy", 32'(bus.busy), 0);
    check("b_end_q", 32'(bus.q), 32'h44);
    bus.req = 4'b0010;
    step();
    check("c_gnt1", 32'(bus.gnt), 32'b0010);
    step();
    check("c_q1", 32'(bus.q), 32'h22);
    bus.req = 4'b0100;
    step();
    check("c_gnt2", 32'(bus.gnt), 32'b0100);
    check("c_owner2", 32'(bus.owner), 2);
    check("c_q_hold", 32'(bus.q), 32'h22);
    check("c_qv0", 32'(bus.q_valid), 0);
    step();
    check("d_q", 32'(bus.q), 32'h33);
    #2 reset = 1'b0;
    #1;
    check("d_gnt", 32'(bus.gnt), 0);
    check("d_q0", 32'(bus.q), 0);
    check("d_busy", 32'(bus.busy), 0);
    check("d_qv", 32'(bus.q_valid), 0);
    reset   = 1'b1;
    bus.req = 4'b1010;
    step();
    check("d_ptr0_gnt", 32'(bus.gnt), 32'b0010);
    check("d_ptr0_owner", 32'(bus.owner), 1);
    pulse_reset();
    bus.req = 4'b1001;
    for (int k = 1; k <= 12; k++) begin
      step();
`ifdef DFF_ARB_TIMEOUT_EN
      eg = (((k - 1) / 5) % 2 == 1) ? 4'b1000 : 4'b0001;
      ev = ((k - 1) % 5 != 0);
`else
      eg = 4'b0001;
      ev = (k != 1);
`endif
      check($sformatf("e_gnt_k%0d", k), 32'(bus.gnt), 32'(eg));
      check($sformatf("e_qv_k%0d", k), 32'(bus.q_valid), 32'(ev));
    end
    bus.req = 4'b0001;
    for (int k = 0; k < 6; k++) begin
      step();
      check($sformatf("f_gnt_k%0d", k), 32'(bus.gnt), 32'b0001);
    end
    check("f_q", 32'(bus.q), 32'h11);
    bus.req = 4'b0000;
    step();
    check("f_idle_busy", 32'(bus.busy), 0);
    check("f_idle_q", 32'(bus.q), 32'h11);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/dff_share_arbiter.md
DFF_SHARE_ARBITER -- requirements
Module: dff_share_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing the register (2..8).
REQ-002 Parameter WIDTH, default 8, width of the shared data register.
REQ-003 Parameter MAX_HOLD, default 4, maximum consecutive owned cycles before forced rotation (1..255).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset; assertion clears all state immediately.
REQ-006 req  input  N_REQ  per-requester request, level-sensitive.
REQ-007 wdata  input  N_REQ*WIDTH  per-requester write data; slice i = bits [i*WIDTH +: WIDTH].
REQ-008 gnt  output  N_REQ  one-hot grant, registered.
REQ-009 owner  output  clog2(N_REQ)  index of current grantee; valid only while busy=1.
REQ-010 q  output  WIDTH  shared register contents.
REQ-011 q_valid  output  1  high for each cycle q holds data captured on the previous edge.
REQ-012 busy  output  1  high while state is OWN.

Function
REQ-013 FSM states: IDLE, OWN; no other states.
REQ-014 IDLE: on an edge with any req bit high, select a winner round-robin starting at ptr, load gnt/owner, go to OWN; latency req->gnt is exactly one edge.
REQ-015 Round-robin: search order ptr, ptr+1, ... wrapping modulo N_REQ; after each grant ends, ptr = ending owner+1 mod N_REQ.
REQ-016 OWN, each edge with req[owner]=1: q <= wdata[owner], q_valid <= 1, hold counter increments (saturating at MAX_HOLD).
REQ-017 OWN, edge with req[owner]=0: q unchanged, q_valid <= 0; if other req pending, grant next winner on that same edge (no idle cycle); else gnt <= 0, go IDLE.
REQ-018 gnt is zero or one-hot at all times; never two bits high.
REQ-019 Hold counter clears to 0 on every new grant, including back-to-back switches.
REQ-020 q retains its last value while IDLE; q_valid = 0 in IDLE and on the first OWN cycle.
REQ-021 Simultaneous owner drop and new requests on the same edge: owner drop wins, switch to next winner per REQ-017.
REQ-022 A requester dropping req while not granted loses nothing; no request queuing or memory.
REQ-023 wdata of non-owners is ignored.

Reset
REQ-024 On reset low: state=IDLE, gnt=0, owner=0, q=0, q_valid=0, busy=0, ptr=0, hold counter=0, asynchronously.
REQ-025 Reset mid-grant aborts the grant; first grant after release follows REQ-014 from ptr=0.
REQ-026 Reset release is synchronous to clk in effect; first state change no earlier than the first rising edge after release.

Configuration
REQ-027 Macro DFF_ARB_TIMEOUT_EN compiles in forced rotation.
REQ-028 With DFF_ARB_TIMEOUT_EN: when hold counter equals MAX_HOLD and any other req is high, the owner loses grant on that edge and the next round-robin winner is granted the same edge.
REQ-029 With DFF_ARB_TIMEOUT_EN and no other req pending, owner keeps grant; counter stays saturated.
REQ-030 Without DFF_ARB_TIMEOUT_EN: no hold counter logic; owner keeps grant until it drops req; MAX_HOLD ignored.

Verification
REQ-031 Reset low, then req=4'b0001, wdata[0]=8'hA5 -> gnt=0001 after 1 edge, q=8'hA5, q_valid=1 after 2 edges.
REQ-032 req=4'b1111 from IDLE after reset, each drops after 2 owned cycles -> grant order 0,1,2,3, no idle cycles between.
REQ-033 Owner 1 drops req same edge req[2] rises -> gnt goes 0010 -> 0100 on one edge, q holds last owner-1 data.
REQ-034 DFF_ARB_TIMEOUT_EN, MAX_HOLD=4, req[0] and req[3] held high -> gnt alternates 0001/1000 every 4 captures; without macro gnt stays 0001.
REQ-035 Reset asserted mid-grant with gnt=0100 -> gnt, q, busy, q_valid zero immediately, before next clk edge.
